// File: rtl/ixc_gfifo_pkg.sv
// Shared definitions for the GFIFO input-side write arbiter and read logic.
// Header word field offsets, arbiter FSM states and default array depth.
package ixc_gfifo_pkg;

    localparam int LOG2_NUM_WORDS_DEF = 15;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_TID_LSB = 16;
    localparam int HDR_MARK    = 63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_XFER,
        ST_COMMIT
    } arb_state_e;

endpackage

// File: rtl/ixc_gfifo_wr_arb_pick.sv
// Combinational round-robin picker: first valid requester after `last_i`.
// Shared with the GFIFO read side.
module ixc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] last_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    // Walk the ring backwards so the nearest successor of last_i wins.
    always_comb begin
        logic [IW-1:0] c;
        any_o = 1'b0;
        idx_o = '0;
        c     = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(last_i) + k) % N);
            if (valid_i[c]) begin
                any_o = 1'b1;
                idx_o = c;
            end
        end
    end

endmodule

// File: rtl/ixc_gfifo_wr_arb.sv
// Packet-granular round-robin arbiter for the GFIFO input SFIFO write port.
// Optional per-requester packet counters: define IXC_GFIFO_ARB_STATS_EN.
module ixc_gfifo_wr_arb
    import ixc_gfifo_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int DW             = 256,
    parameter int LOG2_NUM_WORDS = LOG2_NUM_WORDS_DEF,
    parameter int PW             = 16
) (
    input  logic                        fclk,
    input  logic                        hssReset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*PW-1:0]          req_len,
    input  logic [NREQ*PW-1:0]          req_tid,
    input  logic [NREQ*DW-1:0]          req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        fifo_wen,
    output logic [LOG2_NUM_WORDS-1:0]   fifo_waddr,
    output logic [DW-1:0]               fifo_wdata,
    output logic [LOG2_NUM_WORDS:0]     fifo_wptr,
    input  logic [LOG2_NUM_WORDS:0]     fifo_rptr,
    output logic [PW-1:0]               grant_tid,
    output logic                        busy
`ifdef IXC_GFIFO_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0]          pkt_cnt
`endif
);

    localparam int AW = LOG2_NUM_WORDS;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    arb_state_e      state_q;
    logic [IW-1:0]   g_q;
    logic [IW-1:0]   last_q;
    logic [PW-1:0]   len_q;
    logic [PW-1:0]   rem_q;
    logic [PW-1:0]   gtid_q;
    logic [AW:0]     xptr_q;
    logic [AW:0]     wptr_q;
    logic            wen_q;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;

    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic [AW:0]     used_w;
    logic [AW:0]     free_w;
    logic [PW:0]     need_w;
    logic            fits_w;

    function automatic logic [DW-1:0] hdr_word(
        input logic [PW-1:0] l,
        input logic [PW-1:0] t
    );
        logic [DW-1:0] h;
        h                     = '0;
        h[HDR_LEN_LSB +: PW]  = l;
        h[HDR_TID_LSB +: PW]  = t;
        h[HDR_MARK]           = 1'b1;
        return h;
    endfunction

    ixc_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .valid_i (req_valid),
        .last_i  (last_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    // Occupancy uses the wrap bit, so free ranges 0..DEPTH.
    assign used_w = xptr_q - fifo_rptr;
    assign free_w = DEPTH - used_w;
    assign need_w = (PW+1)'(len_q) + (PW+1)'(1);
    assign fits_w = 32'(need_w) <= 32'(free_w);

    always_comb begin
        req_ready = '0;
        if (state_q == ST_XFER) req_ready[g_q] = 1'b1;
    end

    always_ff @(posedge fclk) begin
        if (hssReset) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            last_q  <= IW'(NREQ - 1);
            len_q   <= '0;
            rem_q   <= '0;
            gtid_q  <= '0;
            xptr_q  <= '0;
            wptr_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        g_q     <= pick_idx;
                        len_q   <= req_len[int'(pick_idx)*PW +: PW];
                        gtid_q  <= req_tid[int'(pick_idx)*PW +: PW];
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (fits_w) begin
                        wen_q   <= 1'b1;
                        waddr_q <= xptr_q[AW-1:0];
                        wdata_q <= hdr_word(len_q, gtid_q);
                        xptr_q  <= xptr_q + (AW+1)'(1);
                        rem_q   <= len_q;
                        state_q <= (len_q == '0) ? ST_COMMIT : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (req_valid[g_q]) begin
                        wen_q   <= 1'b1;
                        waddr_q <= xptr_q[AW-1:0];
                        wdata_q <= req_data[int'(g_q)*DW +: DW];
                        xptr_q  <= xptr_q + (AW+1)'(1);
                        rem_q   <= rem_q - PW'(1);
                        if (rem_q == PW'(1)) state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    wptr_q  <= xptr_q;
                    last_q  <= g_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wen   = wen_q;
    assign fifo_waddr = waddr_q;
    assign fifo_wdata = wdata_q;
    assign fifo_wptr  = wptr_q;
    assign grant_tid  = gtid_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef IXC_GFIFO_ARB_STATS_EN
    logic [31:0] cnt_q [NREQ];

    always_ff @(posedge fclk) begin
        if (hssReset) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (state_q == ST_COMMIT) begin
            cnt_q[g_q] <= cnt_q[g_q] + 32'd1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        assign pkt_cnt[i*32 +: 32] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_ixc_gfifo_wr_arb.sv
// Scoreboard bench for ixc_gfifo_wr_arb: producer model per requester,
// write monitor, and one task per scenario.
module tb_ixc_gfifo_wr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 256;
    localparam int AW   = 15;
    localparam int PW   = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic                 fclk = 1'b0;
    logic                 hssReset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*PW-1:0]   req_len = '0;
    logic [NREQ*PW-1:0]   req_tid = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_wen;
    logic [AW-1:0]        fifo_waddr;
    logic [DW-1:0]        fifo_wdata;
    logic [AW:0]          fifo_wptr;
    logic [AW:0]          fifo_rptr = '0;
    logic [PW-1:0]        grant_tid;
    logic                 busy;
`ifdef IXC_GFIFO_ARB_STATS_EN
    logic [NREQ*32-1:0]   pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int          pk_req  [NREQ];
    int          pk_done [NREQ];
    int          pk_len  [NREQ];
    int          beat    [NREQ];
    logic [15:0] pk_tid  [NREQ] = '{default: '0};

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   wen_cnt = 0;
    int   rdy_cnt = 0;
    int   wp_chg = 0;
    int   wen_at_chg = 0;
    logic [AW:0] wp_prev = '0;

    ixc_gfifo_wr_arb #(
        .NREQ(NREQ), .DW(DW), .LOG2_NUM_WORDS(AW), .PW(PW)
    ) dut (
        .fclk       (fclk),
        .hssReset   (hssReset),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_tid    (req_tid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wen   (fifo_wen),
        .fifo_waddr (fifo_waddr),
        .fifo_wdata (fifo_wdata),
        .fifo_wptr  (fifo_wptr),
        .fifo_rptr  (fifo_rptr),
        .grant_tid  (grant_tid),
        .busy       (busy)
`ifdef IXC_GFIFO_ARB_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    always #5 fclk = ~fclk;

    function automatic logic [DW-1:0] beat_word(int i, logic [15:0] t, int b);
        return {8'(i), t, 32'(b), 8'hA5, 192'(0)};
    endfunction

    function automatic logic [DW-1:0] hdr_w(logic [15:0] l, logic [15:0] t);
        logic [DW-1:0] h;
        h = '0;
        h[15:0] = l;
        h[31:16] = t;
        h[63] = 1'b1;
        return h;
    endfunction

    // Write monitor: pointer change is recorded before the write count.
    always @(negedge fclk) begin
        if (fifo_wptr !== wp_prev) begin
            wp_chg++;
            wen_at_chg = wen_cnt;
            wp_prev = fifo_wptr;
        end
        if (fifo_wen === 1'b1) begin
            obs_q.push_back('{a: fifo_waddr, d: fifo_wdata});
            wen_cnt++;
        end
        if (|req_ready) rdy_cnt++;
    end

    // Producer model: sends pk_req - pk_done packets per requester.
    initial begin
        logic [NREQ-1:0] fire;
        logic            rst_s;
        logic            hz;
        logic [15:0]     ht;
        forever begin
            @(negedge fclk);
            fire  = req_valid & req_ready;
            rst_s = hssReset;
            hz    = fifo_wen && fifo_wdata[63] && (fifo_wdata[15:0] == 16'h0);
            ht    = fifo_wdata[31:16];
            @(posedge fclk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rst_s) begin
                    beat[i] = 0;
                end else if (fire[i]) begin
                    beat[i]++;
                    if (beat[i] == pk_len[i]) begin
                        beat[i] = 0;
                        pk_done[i]++;
                    end
                end else if (req_valid[i] && pk_len[i] == 0 && hz && ht == pk_tid[i]) begin
                    pk_done[i]++;
                end
                req_valid[i]          = pk_done[i] < pk_req[i];
                req_len[i*PW +: PW]   = 16'(pk_len[i]);
                req_tid[i*PW +: PW]   = pk_tid[i];
                req_data[i*DW +: DW]  = beat_word(i, pk_tid[i], beat[i]);
            end
        end
    end

    task automatic do_reset();
        @(posedge fclk);
        #1;
        hssReset  = 1'b1;
        fifo_rptr = '0;
        repeat (2) @(posedge fclk);
        @(negedge fclk);
        for (int i = 0; i < NREQ; i++) pk_req[i] = pk_done[i];
        @(posedge fclk);
        #1;
        hssReset = 1'b0;
        @(negedge fclk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fifo_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", fifo_wen); end
        checks++;
        if (fifo_waddr !== '0) begin errors++; $display("FAIL rst_waddr: got %h want 0", fifo_waddr); end
        checks++;
        if (fifo_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h want 0", fifo_wdata); end
        checks++;
        if (fifo_wptr !== '0) begin errors++; $display("FAIL rst_wptr: got %h want 0", fifo_wptr); end
        checks++;
        if (grant_tid !== '0) begin errors++; $display("FAIL rst_tid: got %h want 0", grant_tid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    endtask

    task automatic test_single();
        int base, bw, bc, ob;
        wr_t e;
        do_reset();
        base = obs_q.size();
        bw = wen_cnt;
        bc = wp_chg;
        exp_q.push_back('{a: 15'd0, d: hdr_w(16'd3, 16'h0012)});
        for (int b = 0; b < 3; b++) exp_q.push_back('{a: AW'(b + 1), d: beat_word(0, 16'h0012, b)});
        pk_len[0] = 3; pk_tid[0] = 16'h0012; pk_req[0]++;
        for (int c = 0; c < 100 && fifo_wptr !== 16'd4; c++) @(negedge fclk);
        #1;
        checks++;
        if (fifo_wptr !== 16'd4) begin errors++; $display("FAIL single_wptr: got %0d want 4", fifo_wptr); end
        checks++;
        if (wp_chg - bc != 1) begin errors++; $display("FAIL single_wptr_once: got %0d changes want 1", wp_chg - bc); end
        checks++;
        if (wen_at_chg - bw != 4) begin errors++; $display("FAIL single_wptr_order: got %0d writes before commit want 4", wen_at_chg - bw); end
        ob = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ob >= obs_q.size()) begin
                errors++; $display("FAIL single_wr: got none, want addr %h data %h", e.a, e.d);
            end else if (obs_q[ob] !== e) begin
                errors++; $display("FAIL single_wr: got addr %h data %h, want addr %h data %h", obs_q[ob].a, obs_q[ob].d, e.a, e.d);
            end
            ob++;
        end
        checks++;
        if (obs_q.size() != ob) begin errors++; $display("FAIL single_extra: got %0d writes want %0d", obs_q.size() - base, ob - base); end
    endtask

    task automatic test_round_robin();
        int base, ob;
        int order[5] = '{0, 1, 2, 3, 0};
        wr_t e;
        do_reset();
        base = obs_q.size();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{a: AW'(2*k), d: hdr_w(16'd1, 16'(16'h100 + order[k]))});
            exp_q.push_back('{a: AW'(2*k + 1), d: beat_word(order[k], 16'(16'h100 + order[k]), 0)});
        end
        for (int i = 0; i < NREQ; i++) begin
            pk_len[i] = 1; pk_tid[i] = 16'(16'h100 + i);
            pk_req[i] += (i == 0) ? 2 : 1;
        end
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < 50 && fifo_wptr !== 16'(2*k); c++) @(negedge fclk);
            checks++;
            if (fifo_wptr !== 16'(2*k)) begin errors++; $display("FAIL rr_wptr_step: got %0d want %0d", fifo_wptr, 2*k); end
        end
        #1;
        ob = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ob >= obs_q.size()) begin
                errors++; $display("FAIL rr_wr: got none, want addr %h data %h", e.a, e.d);
            end else if (obs_q[ob] !== e) begin
                errors++; $display("FAIL rr_wr: got addr %h data %h, want addr %h data %h", obs_q[ob].a, obs_q[ob].d, e.a, e.d);
            end
            ob++;
        end
    endtask

    task automatic test_zero_len();
        int base, br, ob;
        wr_t e;
        do_reset();
        base = obs_q.size();
        br = rdy_cnt;
        exp_q.push_back('{a: 15'd0, d: hdr_w(16'd0, 16'hFFFF)});
        pk_len[2] = 0; pk_tid[2] = 16'hFFFF; pk_req[2]++;
        for (int c = 0; c < 50 && fifo_wptr !== 16'd1; c++) @(negedge fclk);
        repeat (3) @(negedge fclk);
        #1;
        checks++;
        if (fifo_wptr !== 16'd1) begin errors++; $display("FAIL zero_wptr: got %0d want 1", fifo_wptr); end
        checks++;
        if (rdy_cnt != br) begin errors++; $display("FAIL zero_ready: got %0d ready cycles want 0", rdy_cnt - br); end
        ob = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ob >= obs_q.size()) begin
                errors++; $display("FAIL zero_wr: got none, want addr %h data %h", e.a, e.d);
            end else if (obs_q[ob] !== e) begin
                errors++; $display("FAIL zero_wr: got addr %h data %h, want addr %h data %h", obs_q[ob].a, obs_q[ob].d, e.a, e.d);
            end
            ob++;
        end
        checks++;
        if (obs_q.size() != ob) begin errors++; $display("FAIL zero_extra: got %0d writes want 1", obs_q.size() - base); end
    endtask

    task automatic test_reset_mid();
        int base, ob;
        wr_t e;
        do_reset();
        pk_len[0] = 1; pk_tid[0] = 16'h0050; pk_req[0]++;
        for (int c = 0; c < 50 && fifo_wptr !== 16'd2; c++) @(negedge fclk);
        base = obs_q.size();
        pk_len[0] = 5; pk_tid[0] = 16'h0055; pk_req[0]++;
        for (int c = 0; c < 50 && obs_q.size() - base < 3; c++) @(negedge fclk);
        pk_len[1] = 1; pk_tid[1] = 16'h0066; pk_req[1]++;
        @(posedge fclk);
        #1;
        hssReset = 1'b1;
        repeat (2) @(posedge fclk);
        @(negedge fclk);
        checks++;
        if (fifo_wen !== 1'b0) begin errors++; $display("FAIL mid_wen: got %b want 0", fifo_wen); end
        checks++;
        if (fifo_waddr !== '0) begin errors++; $display("FAIL mid_waddr: got %h want 0", fifo_waddr); end
        checks++;
        if (fifo_wdata !== '0) begin errors++; $display("FAIL mid_wdata: got %h want 0", fifo_wdata); end
        checks++;
        if (fifo_wptr !== '0) begin errors++; $display("FAIL mid_wptr: got %h want 0", fifo_wptr); end
        checks++;
        if (grant_tid !== '0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL mid_ctrl: got tid %h busy %b ready %b want 0 0 0", grant_tid, busy, req_ready);
        end
        @(posedge fclk);
        #1;
        hssReset = 1'b0;
        base = obs_q.size();
        exp_q.push_back('{a: 15'd0, d: hdr_w(16'd5, 16'h0055)});
        for (int b = 0; b < 5; b++) exp_q.push_back('{a: AW'(b + 1), d: beat_word(0, 16'h0055, b)});
        exp_q.push_back('{a: 15'd6, d: hdr_w(16'd1, 16'h0066)});
        exp_q.push_back('{a: 15'd7, d: beat_word(1, 16'h0066, 0)});
        for (int c = 0; c < 20 && busy !== 1'b1; c++) @(negedge fclk);
        checks++;
        if (grant_tid !== 16'h0055) begin errors++; $display("FAIL mid_regrant: got tid %h want 0055", grant_tid); end
        for (int c = 0; c < 100 && fifo_wptr !== 16'd8; c++) @(negedge fclk);
        #1;
        checks++;
        if (fifo_wptr !== 16'd8) begin errors++; $display("FAIL mid_final_wptr: got %0d want 8", fifo_wptr); end
        ob = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ob >= obs_q.size()) begin
                errors++; $display("FAIL mid_wr: got none, want addr %h data %h", e.a, e.d);
            end else if (obs_q[ob] !== e) begin
                errors++; $display("FAIL mid_wr: got addr %h data %h, want addr %h data %h", obs_q[ob].a, obs_q[ob].d, e.a, e.d);
            end
            ob++;
        end
    endtask

    task automatic test_full_stall();
        int base, bw, br, ob;
        wr_t e;
        do_reset();
        base = obs_q.size();
        pk_len[0] = 32765; pk_tid[0] = 16'h0AAA; pk_req[0]++;
        for (int c = 0; c < 40000 && fifo_wptr !== 16'd32766; c++) @(negedge fclk);
        #1;
        checks++;
        if (fifo_wptr !== 16'd32766) begin errors++; $display("FAIL fill_wptr: got %0d want 32766", fifo_wptr); end
        checks++;
        if (obs_q.size() - base != 32766) begin errors++; $display("FAIL fill_count: got %0d want 32766", obs_q.size() - base); end
        pk_len[0] = 2; pk_tid[0] = 16'h0BBB; pk_req[0]++;
        bw = wen_cnt;
        br = rdy_cnt;
        repeat (12) @(negedge fclk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
        checks++;
        if (wen_cnt != bw) begin errors++; $display("FAIL stall_wen: got %0d writes want 0", wen_cnt - bw); end
        checks++;
        if (rdy_cnt != br || req_ready !== '0) begin errors++; $display("FAIL stall_ready: got %0d ready cycles want 0", rdy_cnt - br); end
        base = obs_q.size();
        exp_q.push_back('{a: 15'h7FFE, d: hdr_w(16'd2, 16'h0BBB)});
        exp_q.push_back('{a: 15'h7FFF, d: beat_word(0, 16'h0BBB, 0)});
        exp_q.push_back('{a: 15'h0000, d: beat_word(0, 16'h0BBB, 1)});
        fifo_rptr = 16'd1;
        for (int c = 0; c < 50 && fifo_wptr !== 16'h8001; c++) @(negedge fclk);
        #1;
        checks++;
        if (fifo_wptr !== 16'h8001) begin errors++; $display("FAIL stall_wptr: got %h want 8001", fifo_wptr); end
        ob = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ob >= obs_q.size()) begin
                errors++; $display("FAIL stall_wr: got none, want addr %h data %h", e.a, e.d);
            end else if (obs_q[ob] !== e) begin
                errors++; $display("FAIL stall_wr: got addr %h data %h, want addr %h data %h", obs_q[ob].a, obs_q[ob].d, e.a, e.d);
            end
            ob++;
        end
    endtask

`ifdef IXC_GFIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        pk_len[1] = 1; pk_tid[1] = 16'h0071; pk_req[1] += 5;
        for (int c = 0; c < 200 && fifo_wptr !== 16'd10; c++) @(negedge fclk);
        @(negedge fclk);
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (pkt_cnt[i*32 +: 32] !== ((i == 1) ? 32'd5 : 32'd0)) begin
                errors++; $display("FAIL stats_cnt%0d: got %0d want %0d", i, pkt_cnt[i*32 +: 32], (i == 1) ? 5 : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_reset_mid();
        test_full_stall();
`ifdef IXC_GFIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
